// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO: binary/Gray read pointer,
// look-ahead empty, almost-empty, fill level and underflow pulse.
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rinc,
  input  logic [PTR_WIDTH-1:0]  rq2_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic                  rempty,
  output logic                  rempty_almost,
  output logic [PTR_WIDTH-1:0]  rlevel,
  output logic                  rd_underflow
);

  localparam logic [PTR_WIDTH:0] AE_TH = AE_THRESH[PTR_WIDTH:0];

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] rbin_next;
  logic [PTR_WIDTH-1:0] rgray_next;
  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] level_next;
  logic                 rd_en;

  assign rd_en      = rinc & ~rempty;
  assign rbin_next  = rbin + {{(PTR_WIDTH-1){1'b0}}, rd_en};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign wbin       = gray2bin(rq2_wptr);
  // Modulo subtraction: the wrap bit keeps a full FIFO distinct from an empty one.
  assign level_next = wbin - rbin_next;
  assign raddr      = rbin[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rempty_almost <= 1'b1;
      rlevel        <= '0;
      rd_underflow  <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      rempty_almost <= ({1'b0, level_next} <= AE_TH);
      rlevel        <= level_next;
      rd_underflow  <= rinc & rempty;
    end
  end

endmodule
